// File: rtl/execute_stage_mdu.sv
// execute_stage_mdu: EX stage with forwarding, ALU, branch resolution, E/M register and a multi-cycle MUL/DIV unit with HI/LO
module execute_stage_mdu #(
  parameter int XLEN = 32,
  parameter int RA_W = 5,
  parameter int MUL_LAT = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            regwriteE,
  input  logic            memwriteE,
  input  logic            isloadE,
  input  logic            memreadE,
  input  logic            branchE,
  input  logic            jumpE,
  input  logic            isimmediateE,
  input  logic [3:0]      alusignalE,
  input  logic [2:0]      mduopE,
  input  logic [XLEN-1:0] op1E,
  input  logic [XLEN-1:0] op2E,
  input  logic [XLEN-1:0] immxE,
  input  logic [XLEN-1:0] jumpoffset,
  input  logic [XLEN-1:0] pcplus4E,
  input  logic [RA_W-1:0] rdE,
  input  logic [1:0]      forwardaE,
  input  logic [1:0]      forwardbE,
  input  logic [XLEN-1:0] aluresultW,
  input  logic [XLEN-1:0] readdataW,
  output logic            stallE,
  output logic            isbranchtakenE,
  output logic [XLEN-1:0] branchtargetE,
  output logic            regwriteM,
  output logic            memwriteM,
  output logic            isloadM,
  output logic            memreadM,
  output logic [RA_W-1:0] rdM,
  output logic [XLEN-1:0] pcplus4M,
  output logic [XLEN-1:0] aluresultM,
  output logic [XLEN-1:0] writedataM
);
  localparam int SW = $clog2(XLEN);
  localparam int CW = $clog2(XLEN + MUL_LAT + 1);
  localparam logic [1:0] ST_IDLE = 2'd0, ST_MUL = 2'd1, ST_DIV = 2'd2;
  logic [1:0]        r_state, w_next;
  logic [CW-1:0]     r_cnt;
  logic              r_sgn;
  logic [XLEN-1:0]   r_hi, r_lo, r_a, r_b, r_quo, r_rem, r_dvs;
  logic [XLEN-1:0]   w_a, w_b, w_alub, w_alu, w_q, w_r;
  logic [XLEN:0]     w_shift, w_trial;
  logic [2*XLEN-1:0] w_ea, w_eb, w_prod;
  logic              w_issue, w_isdiv, w_sgnop, w_kill;
  assign w_a = forwardaE == 2'd0 ? op1E : forwardaE == 2'd1 ? aluresultW :
               forwardaE == 2'd2 ? aluresultM : readdataW;
  assign w_b = forwardbE == 2'd0 ? op2E : forwardbE == 2'd1 ? aluresultW :
               forwardbE == 2'd2 ? aluresultM : readdataW;
  assign w_alub = isimmediateE ? immxE : w_b;
  always_comb begin
    w_alu = '0;
    case (alusignalE)
      4'd0:  w_alu = w_a + w_alub;
      4'd1:  w_alu = w_a - w_alub;
      4'd2:  w_alu = w_a & w_alub;
      4'd3:  w_alu = w_a | w_alub;
      4'd4:  w_alu = w_a ^ w_alub;
      4'd5:  w_alu = ~(w_a | w_alub);
      4'd6:  w_alu = {{(XLEN-1){1'b0}}, $signed(w_a) < $signed(w_alub)};
      4'd7:  w_alu = {{(XLEN-1){1'b0}}, w_a < w_alub};
      4'd8:  w_alu = w_a << w_alub[SW-1:0];
      4'd9:  w_alu = w_a >> w_alub[SW-1:0];
      4'd10: w_alu = $signed(w_a) >>> w_alub[SW-1:0];
      4'd11: w_alu = {{(XLEN-1){1'b0}}, w_a == w_alub};
      4'd12: w_alu = {{(XLEN-1){1'b0}}, w_a != w_alub};
      4'd13: w_alu = w_alub << (XLEN / 2);
      default: w_alu = '0;
    endcase
  end
  assign w_issue = r_state == ST_IDLE && mduopE >= 3'd1 && mduopE <= 3'd4 && !flush;
  assign w_isdiv = mduopE == 3'd3 || mduopE == 3'd4;
  assign w_sgnop = mduopE == 3'd1 || mduopE == 3'd3;
  assign w_ea = r_sgn ? {{XLEN{r_a[XLEN-1]}}, r_a} : {{XLEN{1'b0}}, r_a};
  assign w_eb = r_sgn ? {{XLEN{r_b[XLEN-1]}}, r_b} : {{XLEN{1'b0}}, r_b};
  assign w_prod = w_ea * w_eb;
  // One restoring step: shift the next dividend bit into the partial remainder and try to subtract.
  assign w_shift = {r_rem, r_quo[XLEN-1]};
  assign w_trial = w_shift - {1'b0, r_dvs};
  assign w_q = (r_sgn & (r_a[XLEN-1] ^ r_b[XLEN-1])) ? -r_quo : r_quo;
  assign w_r = (r_sgn & r_a[XLEN-1]) ? -r_rem : r_rem;
  always_ff @(posedge clk)
    if (rst) r_state <= ST_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: w_next = w_issue ? (w_isdiv ? ST_DIV : ST_MUL) : ST_IDLE;
      ST_MUL, ST_DIV: w_next = r_cnt == '0 ? ST_IDLE : r_state;
      default: w_next = ST_IDLE;
    endcase
  end
  always_comb begin
    stallE = r_state != ST_IDLE || w_issue;
    w_kill = stallE || flush;
    isbranchtakenE = !w_kill && (jumpE || (branchE && |w_alu));
    branchtargetE = jumpE ? jumpoffset : pcplus4E + (immxE << 2);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi <= '0;
      r_lo <= '0;
      r_a <= '0;
      r_b <= '0;
      r_quo <= '0;
      r_rem <= '0;
      r_dvs <= '0;
      r_cnt <= '0;
      r_sgn <= 1'b0;
    end else if (w_issue) begin
      r_a <= w_a;
      r_b <= w_b;
      r_sgn <= w_sgnop;
      r_quo <= (w_sgnop && w_a[XLEN-1]) ? -w_a : w_a;
      r_dvs <= (w_sgnop && w_b[XLEN-1]) ? -w_b : w_b;
      r_rem <= '0;
      r_cnt <= w_isdiv ? CW'(XLEN) : CW'(MUL_LAT - 1);
    end else if (r_state != ST_IDLE) begin
      if (r_cnt != '0) begin
        r_cnt <= r_cnt - CW'(1);
        if (r_state == ST_DIV) begin
          r_rem <= w_trial[XLEN] ? w_shift[XLEN-1:0] : w_trial[XLEN-1:0];
          r_quo <= {r_quo[XLEN-2:0], ~w_trial[XLEN]};
        end
      end else if (r_state == ST_MUL) begin
        {r_hi, r_lo} <= w_prod;
      end else begin
        r_hi <= r_b == '0 ? r_a : w_r;
        r_lo <= r_b == '0 ? '1 : w_q;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      regwriteM <= 1'b0;
      memwriteM <= 1'b0;
      isloadM <= 1'b0;
      memreadM <= 1'b0;
      rdM <= '0;
      pcplus4M <= '0;
      aluresultM <= '0;
      writedataM <= '0;
    end else begin
      regwriteM <= regwriteE && !w_kill;
      memwriteM <= memwriteE && !w_kill;
      isloadM <= isloadE && !w_kill;
      memreadM <= memreadE && !w_kill;
      rdM <= rdE;
      pcplus4M <= pcplus4E;
      aluresultM <= mduopE == 3'd5 ? r_hi : mduopE == 3'd6 ? r_lo : w_alu;
      writedataM <= w_b;
    end
  end
endmodule
